// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_if
// Description : Bus bundle between the two masters, the arbiter and the
//               single-port memory. The arbiter uses the slave view; the
//               masters and the memory model together use the master view.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
    parameter int WIDTH = 32
);
    // Master 0 (core) request/response
    logic             m0_req;
    logic             m0_we;
    logic [WIDTH-1:0] m0_adr;
    logic [WIDTH-1:0] m0_wd;
    logic             m0_ack;
    logic [WIDTH-1:0] m0_rd;

    // Master 1 (loader/DMA) request/response
    logic             m1_req;
    logic             m1_we;
    logic [WIDTH-1:0] m1_adr;
    logic [WIDTH-1:0] m1_wd;
    logic             m1_ack;
    logic [WIDTH-1:0] m1_rd;

    // Memory side
    logic             mem_we;
    logic [WIDTH-1:0] mem_adr;
    logic [WIDTH-1:0] mem_wd;
    logic [WIDTH-1:0] mem_rd;

    // Status
    logic             busy;
    logic             owner;

    modport slave (
        input  m0_req, m0_we, m0_adr, m0_wd,
        input  m1_req, m1_we, m1_adr, m1_wd,
        input  mem_rd,
        output m0_ack, m0_rd, m1_ack, m1_rd,
        output mem_we, mem_adr, mem_wd,
        output busy, owner
    );

    modport master (
        output m0_req, m0_we, m0_adr, m0_wd,
        output m1_req, m1_we, m1_adr, m1_wd,
        output mem_rd,
        input  m0_ack, m0_rd, m1_ack, m1_rd,
        input  mem_we, mem_adr, mem_wd,
        input  busy, owner
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Two-master arbiter for a single-port word memory. Master 0
//               wins ties unless master 1 has been passed over STARVE_LIMIT
//               times in a row. Each access spends WAIT+1 cycles in ACCESS
//               and then one RESP cycle carrying the owner's ack pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int WIDTH        = 32,
    parameter int WAIT         = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  wire logic    clk,
    input  wire logic    reset,
    mem_arbiter_if.slave bus
);
    localparam int CW = (WAIT > 0) ? $clog2(WAIT + 1) : 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] c_WAIT_LD = CW'(WAIT);
    localparam logic [SW-1:0] c_LIMIT   = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_wait_cnt;
    logic [SW-1:0]    r_streak;
    logic [WIDTH-1:0] r_adr;
    logic [WIDTH-1:0] r_wd;
    logic             r_we;
    logic             r_owner;
    logic             r_m0_ack;
    logic             r_m1_ack;
    logic [WIDTH-1:0] r_m0_rd;
    logic [WIDTH-1:0] r_m1_rd;

    logic             w_any_req;
    logic             w_grant_m1;
    logic             w_last_beat;

    assign w_any_req   = bus.m0_req | bus.m1_req;
    assign w_last_beat = (r_state == S_ACCESS) && (r_wait_cnt == '0);

    // Master 1 wins when it is alone or when master 0 has used up its streak
    always_comb begin
        w_grant_m1 = 1'b0;
        if (bus.m1_req && (!bus.m0_req || (r_streak == c_LIMIT))) begin
            w_grant_m1 = 1'b1;
        end
    end

    // Arbitration FSM with latched request fields and registered responses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
            r_streak   <= '0;
            r_adr      <= '0;
            r_wd       <= '0;
            r_we       <= 1'b0;
            r_owner    <= 1'b0;
            r_m0_ack   <= 1'b0;
            r_m1_ack   <= 1'b0;
            r_m0_rd    <= '0;
            r_m1_rd    <= '0;
        end else begin
            r_m0_ack <= 1'b0;
            r_m1_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_owner    <= w_grant_m1;
                        r_adr      <= w_grant_m1 ? bus.m1_adr : bus.m0_adr;
                        r_wd       <= w_grant_m1 ? bus.m1_wd  : bus.m0_wd;
                        r_we       <= w_grant_m1 ? bus.m1_we  : bus.m0_we;
                        r_wait_cnt <= c_WAIT_LD;
                        // Streak counts only master-0 wins that kept master 1 waiting
                        if (w_grant_m1 || !bus.m1_req) begin
                            r_streak <= '0;
                        end else if (r_streak != c_LIMIT) begin
                            r_streak <= r_streak + 1'b1;
                        end
                        r_state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (r_wait_cnt != '0) begin
                        r_wait_cnt <= r_wait_cnt - 1'b1;
                    end else begin
                        if (!r_we) begin
                            if (r_owner) begin
                                r_m1_rd <= bus.mem_rd;
                            end else begin
                                r_m0_rd <= bus.mem_rd;
                            end
                        end
                        r_m0_ack <= ~r_owner;
                        r_m1_ack <= r_owner;
                        r_state  <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Write strobe only on the final access beat
    assign bus.mem_we  = w_last_beat & r_we;
    assign bus.mem_adr = r_adr;
    assign bus.mem_wd  = r_wd;
    assign bus.m0_ack  = r_m0_ack;
    assign bus.m1_ack  = r_m1_ack;
    assign bus.m0_rd   = r_m0_rd;
    assign bus.m1_rd   = r_m1_rd;
    assign bus.busy    = (r_state != S_IDLE);
    assign bus.owner   = r_owner;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter. One instance
//               with WAIT=1 and a word memory model, one with WAIT=0 and a
//               fixed read pattern.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
    logic clk;
    logic reset;
    int   compared;
    int   mismatched;

    mem_arbiter_if #(.WIDTH(32)) ifc ();
    mem_arbiter_if #(.WIDTH(32)) ifz ();

    mem_arbiter #(.WIDTH(32), .WAIT(1), .STARVE_LIMIT(4)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    mem_arbiter #(.WIDTH(32), .WAIT(0), .STARVE_LIMIT(4)) u_dut_w0 (
        .clk   (clk),
        .reset (reset),
        .bus   (ifz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word memory for the WAIT=1 instance, preloaded on the first edge
    logic [31:0] mem [0:63];
    bit          mem_init = 1'b0;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= {16'hA5A5, 16'(i * 4)};
            mem_init <= 1'b1;
        end else if (ifc.mem_we) begin
            mem[ifc.mem_adr[7:2]] <= ifc.mem_wd;
        end
    end
    assign ifc.mem_rd = mem[ifc.mem_adr[7:2]];

    // Read-only pattern for the WAIT=0 instance
    assign ifz.mem_rd = (ifz.mem_adr[7:2] == 6'd4) ? 32'h1234_5678 : 32'hFFFF_FFFF;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    logic [9:0] exp_order;

    initial begin
        compared   = 0;
        mismatched = 0;
        exp_order  = 10'b10_0001_0000;
        reset      = 1'b0;
        ifc.m0_req = 1'b0; ifc.m0_we = 1'b0; ifc.m0_adr = '0; ifc.m0_wd = '0;
        ifc.m1_req = 1'b0; ifc.m1_we = 1'b0; ifc.m1_adr = '0; ifc.m1_wd = '0;
        ifz.m0_req = 1'b0; ifz.m0_we = 1'b0; ifz.m0_adr = '0; ifz.m0_wd = '0;
        ifz.m1_req = 1'b0; ifz.m1_we = 1'b0; ifz.m1_adr = '0; ifz.m1_wd = '0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        check("rst_busy",   {31'd0, ifc.busy},   32'd0);
        check("rst_owner",  {31'd0, ifc.owner},  32'd0);
        check("rst_m0_ack", {31'd0, ifc.m0_ack}, 32'd0);
        check("rst_m1_ack", {31'd0, ifc.m1_ack}, 32'd0);
        check("rst_mem_we", {31'd0, ifc.mem_we}, 32'd0);
        check("rst_m0_rd",  ifc.m0_rd,  32'd0);
        check("rst_m1_rd",  ifc.m1_rd,  32'd0);
        check("rst_adr",    ifc.mem_adr, 32'd0);
        check("rst_wd",     ifc.mem_wd,  32'd0);
        reset = 1'b1;

        // m0 write 0x40, then m1 reads it back
        ifc.m0_req = 1'b1; ifc.m0_we = 1'b1; ifc.m0_adr = 32'h40; ifc.m0_wd = 32'hDEAD_BEEF;
        step();
        check("t1_busy",     {31'd0, ifc.busy},   32'd1);
        check("t1_we_early", {31'd0, ifc.mem_we}, 32'd0);
        check("t1_owner",    {31'd0, ifc.owner},  32'd0);
        step();
        check("t1_we_final", {31'd0, ifc.mem_we}, 32'd1);
        check("t1_adr",      ifc.mem_adr, 32'h40);
        check("t1_wd",       ifc.mem_wd,  32'hDEAD_BEEF);
        check("t1_ack_early",{31'd0, ifc.m0_ack}, 32'd0);
        step();
        check("t1_m0_ack",   {31'd0, ifc.m0_ack}, 32'd1);
        check("t1_m1_ack",   {31'd0, ifc.m1_ack}, 32'd0);
        check("t1_we_resp",  {31'd0, ifc.mem_we}, 32'd0);
        ifc.m0_req = 1'b0; ifc.m0_we = 1'b0;
        step();
        check("t1_ack_drop", {31'd0, ifc.m0_ack}, 32'd0);
        check("t1_idle",     {31'd0, ifc.busy},   32'd0);
        ifc.m1_req = 1'b1; ifc.m1_we = 1'b0; ifc.m1_adr = 32'h40;
        step();
        step();
        check("t1_rd_we",    {31'd0, ifc.mem_we}, 32'd0);
        step();
        check("t1_m1_ack2",  {31'd0, ifc.m1_ack}, 32'd1);
        check("t1_m0_ack2",  {31'd0, ifc.m0_ack}, 32'd0);
        check("t1_m1_rd",    ifc.m1_rd, 32'hDEAD_BEEF);
        check("t1_owner2",   {31'd0, ifc.owner},  32'd1);
        ifc.m1_req = 1'b0;
        step();
        check("t1_m1_ack_drop", {31'd0, ifc.m1_ack}, 32'd0);

        // WAIT=0 read of 0x10
        ifz.m0_req = 1'b1; ifz.m0_we = 1'b0; ifz.m0_adr = 32'h10;
        step();
        check("z_busy_a",  {31'd0, ifz.busy},   32'd1);
        check("z_adr",     ifz.mem_adr, 32'h10);
        check("z_we",      {31'd0, ifz.mem_we}, 32'd0);
        check("z_ack_a",   {31'd0, ifz.m0_ack}, 32'd0);
        step();
        check("z_ack",     {31'd0, ifz.m0_ack}, 32'd1);
        check("z_rd",      ifz.m0_rd, 32'h1234_5678);
        check("z_busy_b",  {31'd0, ifz.busy},   32'd1);
        ifz.m0_req = 1'b0;
        step();
        check("z_busy_c",  {31'd0, ifz.busy},   32'd0);
        check("z_ack_c",   {31'd0, ifz.m0_ack}, 32'd0);

        // Both masters requesting continuously: starvation guard
        ifc.m0_req = 1'b1; ifc.m0_we = 1'b0; ifc.m0_adr = 32'h80;
        ifc.m1_req = 1'b1; ifc.m1_we = 1'b0; ifc.m1_adr = 32'h84;
        for (int g = 0; g < 10; g++) begin
            step();
            check($sformatf("t2_owner%0d", g), {31'd0, ifc.owner}, {31'd0, exp_order[g]});
            step();
            step();
            check($sformatf("t2_acks%0d", g), {30'd0, ifc.m1_ack, ifc.m0_ack},
                  exp_order[g] ? 32'd2 : 32'd1);
            check($sformatf("t2_rd%0d", g), exp_order[g] ? ifc.m1_rd : ifc.m0_rd,
                  exp_order[g] ? 32'hA5A5_0084 : 32'hA5A5_0080);
            step();
        end
        ifc.m0_req = 1'b0; ifc.m1_req = 1'b0;

        // m1 alone, m0 arrives during m1's access
        ifc.m1_req = 1'b1; ifc.m1_we = 1'b0; ifc.m1_adr = 32'h40;
        step();
        ifc.m0_req = 1'b1; ifc.m0_we = 1'b0; ifc.m0_adr = 32'h40;
        check("t3_owner_m1", {31'd0, ifc.owner}, 32'd1);
        step();
        step();
        check("t3_m1_ack",   {31'd0, ifc.m1_ack}, 32'd1);
        check("t3_m0_ack",   {31'd0, ifc.m0_ack}, 32'd0);
        check("t3_m1_rd",    ifc.m1_rd, 32'hDEAD_BEEF);
        ifc.m1_req = 1'b0;
        step();
        step();
        check("t3_owner_m0", {31'd0, ifc.owner}, 32'd0);
        check("t3_busy",     {31'd0, ifc.busy},  32'd1);
        step();
        step();
        check("t3_m0_ack2",  {31'd0, ifc.m0_ack}, 32'd1);
        check("t3_m0_rd",    ifc.m0_rd, 32'hDEAD_BEEF);
        ifc.m0_req = 1'b0;
        step();

        // m1 write with req dropped right after grant
        ifc.m1_req = 1'b1; ifc.m1_we = 1'b1; ifc.m1_adr = 32'h48; ifc.m1_wd = 32'h0BAD_CAFE;
        step();
        ifc.m1_req = 1'b0; ifc.m1_we = 1'b0;
        step();
        check("t6_we",      {31'd0, ifc.mem_we}, 32'd1);
        check("t6_adr",     ifc.mem_adr, 32'h48);
        step();
        check("t6_ack",     {31'd0, ifc.m1_ack}, 32'd1);
        check("t6_rd_hold", ifc.m1_rd, 32'hDEAD_BEEF);
        step();
        check("t6_ack_drop",{31'd0, ifc.m1_ack}, 32'd0);
        check("t6_idle_a",  {31'd0, ifc.busy},   32'd0);
        step();
        check("t6_idle_b",  {31'd0, ifc.busy},   32'd0);
        check("t6_mem",     mem[18], 32'h0BAD_CAFE);

        // Reset in the middle of a write access
        ifc.m0_req = 1'b1; ifc.m0_we = 1'b1; ifc.m0_adr = 32'h44; ifc.m0_wd = 32'hCAFE_F00D;
        step();
        check("t5_busy_pre", {31'd0, ifc.busy}, 32'd1);
        reset = 1'b0;
        #1;
        check("t5_busy",   {31'd0, ifc.busy},   32'd0);
        check("t5_we",     {31'd0, ifc.mem_we}, 32'd0);
        check("t5_m0_ack", {31'd0, ifc.m0_ack}, 32'd0);
        check("t5_adr",    ifc.mem_adr, 32'd0);
        check("t5_wd",     ifc.mem_wd,  32'd0);
        check("t5_m0_rd",  ifc.m0_rd,   32'd0);
        check("t5_m1_rd",  ifc.m1_rd,   32'd0);
        step();
        check("t5_we_hold", {31'd0, ifc.mem_we}, 32'd0);
        step();
        check("t5_mem_kept", mem[17], 32'hA5A5_0044);
        reset = 1'b1;
        step();
        check("t5_owner_after", {31'd0, ifc.owner}, 32'd0);
        check("t5_busy_after",  {31'd0, ifc.busy},  32'd1);
        step();
        check("t5_we_after",  {31'd0, ifc.mem_we}, 32'd1);
        check("t5_adr_after", ifc.mem_adr, 32'h44);
        step();
        check("t5_ack_after", {31'd0, ifc.m0_ack}, 32'd1);
        ifc.m0_req = 1'b0; ifc.m0_we = 1'b0;
        step();
        check("t5_mem_written", mem[17], 32'hCAFE_F00D);
        check("t5_rd_unchanged", ifc.m0_rd, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates the single-port, word-aligned unified memory between two masters with a request/acknowledge handshake.
- Master 0 is the multicycle ARM core's data/instruction port. Master 1 is a loader/DMA port.
- Sits between the masters and the memory. Adds a configurable number of wait states and a starvation guard so master 1 always makes progress.

Parameters:
- WIDTH, 32, address and data width.
- WAIT, 1, extra memory cycles per access (0 allowed); an access occupies WAIT+1 cycles in ACCESS.
- STARVE_LIMIT, 4, maximum consecutive master-0 grants while master 1 is waiting (must be ≥1).

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- m0_req  in  1  master 0 request (level)
- m0_we  in  1  master 0 write enable (1 = write)
- m0_adr  in  WIDTH  master 0 byte address
- m0_wd  in  WIDTH  master 0 write data
- m0_ack  out  1  one-cycle completion pulse for master 0
- m0_rd  out  WIDTH  master 0 read data, valid while m0_ack=1
- m1_req, m1_we, m1_adr, m1_wd, m1_ack, m1_rd: same as master 0, for master 1
- mem_we  out  1  memory write strobe
- mem_adr  out  WIDTH  memory address
- mem_wd  out  WIDTH  memory write data
- mem_rd  in  WIDTH  memory read data (combinational from mem_adr)
- busy  out  1  1 when state ≠ IDLE
- owner  out  1  master currently or last granted (0/1)

Behaviour:
- Reset (reset=0, async):
  - State IDLE.
  - Wait counter 0, streak counter 0.
  - All latched fields 0: adr, wd, we, owner.
  - m0_ack=m1_ack=0, m0_rd=m1_rd=0, mem_we=0.
- Outputs mem_adr/mem_wd always drive the latched adr/wd registers; they hold their last value in IDLE.
- States: IDLE, ACCESS, RESP.
- IDLE: sample requests on each edge.
  - Neither requesting: stay IDLE.
  - Only one requesting: grant it.
  - Both requesting: grant m0, unless streak == STARVE_LIMIT, in which case grant m1.
  - On grant: latch adr/we/wd and owner, load wait counter with WAIT, go to ACCESS.
  - Streak on grant:
    - m0 granted while m1_req=1: streak+1, saturating at STARVE_LIMIT.
    - m0 granted while m1_req=0: streak cleared.
    - m1 granted: streak cleared.
- ACCESS:
  - Counter > 0: decrement, stay.
  - Counter == 0 (final access cycle):
    - mem_we = latched we (combinational, this cycle only).
    - For a read, register mem_rd into the owner's rd output.
    - Go to RESP.
  - mem_we is 0 in every other cycle and state.
- RESP:
  - Owner's ack = 1 for exactly this cycle; the other ack stays 0.
  - Requests are not sampled; next state IDLE.
- rd outputs hold their value after ack. A write access leaves the owner's rd unchanged.
- Latency: request sampled at edge E → final access cycle ends at edge E+WAIT+1 → ack high in the cycle after edge E+WAIT+1.
  - Request-to-ack is WAIT+2 cycles.
  - Minimum issue interval per access is WAIT+3 cycles (one IDLE cycle between accesses).
- Requests are level-sensitive.
  - A master keeps req/adr/we/wd stable until it sees ack.
  - If req is still 1 in the IDLE cycle after ack, that is a new request.
  - Request fields and req changes after grant are ignored; the access always completes.
- Address bits [1:0] are passed through unchanged; memory ignores them.
- Reset asserted mid-access: abort immediately to reset values. No ack is issued and no further mem_we occurs.

Test Plan:
- WAIT=1: m0 write adr=0x40, wd=0xDEADBEEF.
  - mem_we high exactly one cycle with mem_adr=0x40.
  - m0_ack in the 3rd cycle after the sampling edge.
  - Subsequent m1 read of 0x40 returns m1_rd=0xDEADBEEF with m1_ack; m0_ack stays 0.
- Both req held continuously, STARVE_LIMIT=4: grant order m0,m0,m0,m0,m1,m0,m0,m0,m0,m1; streak cleared after each m1 grant.
- Only m1 requesting, then m0 raises req during m1's ACCESS: m1 access completes, m1_ack pulses, m0 granted next IDLE.
- WAIT=0 read of 0x10 (memory value 0x12345678) → m0_rd=0x12345678 and m0_ack two cycles after the sampling edge; busy high for 2 cycles.
- reset driven low during ACCESS of a write: mem_we never asserts, no ack, all outputs 0. After release, a pending m0 req is serviced normally.
- req dropped by master after grant: access still completes and ack still pulses once. No second access occurs.
